// File: rtl/spi_slave_pkg.sv
// Shared types and defaults for the SPI responder.
// inner_clk must run at least 8x sclk so each sclk half-period spans the synchroniser delay.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHIFT      = 2'd1,
    WAIT_DESEL = 2'd2
  } state_t;

  localparam int   SPI_DATA_WIDTH = 16;
  localparam logic SPI_CS_ACTIVE  = 1'b0;
  localparam logic SPI_CPOL       = 1'b0;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser with registered rise/fall pulses aligned to the synchronised level.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic inner_clk,
  input  logic reset,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;

  // Pulses compare the value about to enter the last stage with the last stage,
  // so they go high in the same cycle dout takes its new value.
  always_ff @(posedge inner_clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RST_VAL}};
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      rise   <=  sync_q[STAGES-2] & ~sync_q[STAGES-1];
      fall   <= ~sync_q[STAGES-2] &  sync_q[STAGES-1];
    end
  end

  assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI responder: oversampled LSB-first frame receive with a preloaded response word.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int   DATA_WIDTH  = SPI_DATA_WIDTH,
  parameter logic CS_ACTIVE   = SPI_CS_ACTIVE,
  parameter logic CPOL        = SPI_CPOL,
  parameter int   SYNC_STAGES = 2
) (
  input  logic                  inner_clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int CNT_W = cnt_width(DATA_WIDTH);

  logic sclk_s, sclk_rise, sclk_fall;
  logic cs_s, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic [SYNC_STAGES:0]   flush_pipe;
  logic mosi_s, cs_act, cs_on, sample, primed;

  state_t state, state_d;
  logic start, step, done, abort;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] rx_shift, rx_next, tx_shift, tx_hold;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
    .inner_clk(inner_clk), .reset(reset), .din(sclk),
    .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(~CS_ACTIVE)) u_cs_sync (
    .inner_clk(inner_clk), .reset(reset), .din(cs),
    .dout(cs_s), .rise(cs_rise), .fall(cs_fall)
  );

  // mosi runs through the same depth as sclk so a sample edge sees the matching bit.
  // flush_pipe masks the fake cs edge produced while the chains refill after reset.
  always_ff @(posedge inner_clk or posedge reset) begin
    if (reset) begin
      mosi_q     <= '0;
      flush_pipe <= '0;
    end else begin
      mosi_q     <= {mosi_q[SYNC_STAGES-2:0], mosi};
      flush_pipe <= {flush_pipe[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign mosi_s  = mosi_q[SYNC_STAGES-1];
  assign primed  = flush_pipe[SYNC_STAGES];
  assign cs_act  = (cs_s == CS_ACTIVE);
  assign cs_on   = CS_ACTIVE ? cs_rise : cs_fall;
  assign sample  = CPOL ? sclk_rise : sclk_fall;
  assign rx_next = {mosi_s, rx_shift[DATA_WIDTH-1:1]};

  always_ff @(posedge inner_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    start   = 1'b0;
    step    = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    unique case (state)
      IDLE: begin
        // Without a clean select edge at idle sclk (e.g. cs held through reset) sit out the frame.
        if (primed && cs_act) begin
          if (cs_on && (sclk_s == CPOL)) begin
            state_d = SHIFT;
            start   = 1'b1;
          end else begin
            state_d = WAIT_DESEL;
          end
        end
      end
      SHIFT: begin
        if (!cs_act) begin
          abort   = 1'b1;
          state_d = IDLE;
        end else if (sample) begin
          step = 1'b1;
          if (bit_cnt == CNT_W'(DATA_WIDTH-1)) begin
            done    = 1'b1;
            state_d = WAIT_DESEL;
          end
        end
      end
      WAIT_DESEL: if (!cs_act) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge inner_clk or posedge reset) begin
    if (reset) begin
      miso      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      tx_hold   <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
    end else begin
      frame_err <= abort;
      overrun   <= done & rx_valid & ~rx_ack;
      busy      <= (state_d != IDLE);
      if (tx_load) tx_hold <= tx_data;

      if (start) begin
        tx_shift <= tx_hold;
        rx_shift <= '0;
        bit_cnt  <= '0;
        miso     <= tx_hold[0];
      end else if (step) begin
        rx_shift <= rx_next;
        tx_shift <= tx_shift >> 1;
        bit_cnt  <= bit_cnt + CNT_W'(1);
        miso     <= done ? 1'b0 : tx_shift[1];
      end else if (state_d != SHIFT) begin
        miso <= 1'b0;
      end

      if (done) begin
        rx_data  <= rx_next;
        rx_valid <= 1'b1;
      end else if (rx_ack) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Scenario bench for spi_slave: bit-banged SPI master at inner_clk/8 with a queue scoreboard.
module tb_spi_slave;

  logic        inner_clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0, cs = 1'b1, mosi = 1'b0;
  logic        miso;
  logic [15:0] tx_data = '0;
  logic        tx_load = 1'b0;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_ack = 1'b0;
  logic        busy, frame_err, overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int ovr_cnt  = 0;
  int ferr_cnt = 0;

  logic [15:0] tx_model = '0;
  logic [15:0] exp_rx[$];
  logic [15:0] exp_tx[$];

  spi_slave dut (
    .inner_clk(inner_clk), .reset(reset), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ack(rx_ack), .busy(busy), .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 inner_clk = ~inner_clk;

  always @(posedge inner_clk) begin
    if (overrun)   ovr_cnt  <= ovr_cnt + 1;
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_load(input logic [15:0] v);
    @(negedge inner_clk); tx_data = v; tx_load = 1'b1;
    @(negedge inner_clk); tx_load = 1'b0;
    tx_model = v;
  endtask

  task automatic do_ack();
    @(negedge inner_clk); rx_ack = 1'b1;
    @(negedge inner_clk); rx_ack = 1'b0;
  endtask

  // One bit: leading edge with master read of miso, trailing edge 4 clocks later.
  task automatic sclk_bit(input logic b, output logic m);
    @(negedge inner_clk); mosi = b; sclk = 1'b1; m = miso;
    repeat (4) @(negedge inner_clk);
    sclk = 1'b0;
  endtask

  task automatic spi_frame(input logic [15:0] w, input int nbits, input int load_at,
                           input logic [15:0] load_val, input bit ack_at_done,
                           output logic [15:0] mw, output int lat, output logic busy_mid);
    logic m;
    mw = '0; lat = 0; busy_mid = 1'b0;
    @(negedge inner_clk); cs = 1'b0;
    repeat (4) @(negedge inner_clk);
    for (int i = 0; i < nbits; i++) begin
      sclk_bit(w[i], m);
      mw[i] = m;
      if (i == 8) busy_mid = busy;
      if (i < nbits-1) begin
        for (int k = 1; k <= 3; k++) begin
          @(negedge inner_clk);
          tx_load = (i == load_at) && (k == 1);
          if (tx_load) begin tx_data = load_val; tx_model = load_val; end
        end
      end else begin
        for (int k = 1; k <= 6; k++) begin
          @(negedge inner_clk);
          if (ack_at_done) rx_ack = (k == 2);
          if (rx_valid && lat == 0) lat = k;
        end
        rx_ack = 1'b0;
      end
    end
    @(negedge inner_clk); cs = 1'b1;
    repeat (6) @(negedge inner_clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge inner_clk);
    n_checks++;
    if ({miso, rx_valid, busy, frame_err, overrun} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000", {miso, rx_valid, busy, frame_err, overrun});
    end
    n_checks++;
    if (rx_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_rx_data: got %h expected 0000", rx_data);
    end
    reset = 1'b0;
    repeat (6) @(negedge inner_clk);
  endtask

  task automatic test_basic();
    logic [15:0] mw, e; int lat; logic bm; int o0, f0;
    o0 = ovr_cnt; f0 = ferr_cnt;
    do_load(16'hA5C3);
    exp_tx.push_back(tx_model); exp_rx.push_back(16'h1234);
    spi_frame(16'h1234, 16, -1, 16'h0, 1'b0, mw, lat, bm);
    e = exp_tx.pop_front(); n_checks++;
    if (mw !== e) begin n_fail++; $display("FAIL basic_miso: got %h expected %h", mw, e); end
    n_checks++;
    if (bm !== 1'b1) begin n_fail++; $display("FAIL basic_busy_mid: got %b expected 1", bm); end
    n_checks++;
    if (lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    e = exp_rx.pop_front(); n_checks++;
    if (rx_data !== e || rx_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_rx: got %h/%b expected %h/1", rx_data, rx_valid, e);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_end: got %b expected 0", busy); end
    n_checks++;
    if (ovr_cnt != o0 || ferr_cnt != f0) begin
      n_fail++; $display("FAIL basic_pulses: ovr %0d ferr %0d expected 0 0", ovr_cnt-o0, ferr_cnt-f0);
    end
    do_ack();
    n_checks++;
    if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_ack: got %b expected 0", rx_valid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words[2];
    logic [15:0] mw, e; int lat; logic bm; int o0;
    words[0] = 16'h0001; words[1] = 16'h8000;
    o0 = ovr_cnt;
    for (int j = 0; j < 2; j++) begin
      exp_tx.push_back(tx_model); exp_rx.push_back(words[j]);
      spi_frame(words[j], 16, -1, 16'h0, 1'b0, mw, lat, bm);
      e = exp_tx.pop_front(); n_checks++;
      if (mw !== e) begin n_fail++; $display("FAIL b2b_miso%0d: got %h expected %h", j, mw, e); end
      e = exp_rx.pop_front(); n_checks++;
      if (rx_data !== e || rx_valid !== 1'b1) begin
        n_fail++; $display("FAIL b2b_rx%0d: got %h/%b expected %h/1", j, rx_data, rx_valid, e);
      end
      do_ack();
    end
    n_checks++;
    if (ovr_cnt != o0) begin n_fail++; $display("FAIL b2b_overrun: got %0d pulses expected 0", ovr_cnt-o0); end
  endtask

  task automatic test_overrun();
    logic [15:0] mw, e; int lat; logic bm; int o0;
    o0 = ovr_cnt;
    exp_rx.push_back(16'h1111);
    spi_frame(16'h1111, 16, -1, 16'h0, 1'b0, mw, lat, bm);
    e = exp_rx.pop_front(); n_checks++;
    if (rx_data !== e) begin n_fail++; $display("FAIL ovr_first: got %h expected %h", rx_data, e); end
    exp_rx.push_back(16'h2222);
    spi_frame(16'h2222, 16, -1, 16'h0, 1'b0, mw, lat, bm);
    e = exp_rx.pop_front(); n_checks++;
    if (rx_data !== e || rx_valid !== 1'b1 || ovr_cnt != o0 + 1) begin
      n_fail++;
      $display("FAIL ovr_second: got %h/%b/%0d pulses expected %h/1/1", rx_data, rx_valid, ovr_cnt-o0, e);
    end
    // ack lands on the completion cycle: new word stays valid, no overrun
    exp_rx.push_back(16'h3333);
    spi_frame(16'h3333, 16, -1, 16'h0, 1'b1, mw, lat, bm);
    e = exp_rx.pop_front(); n_checks++;
    if (rx_data !== e || rx_valid !== 1'b1 || ovr_cnt != o0 + 1) begin
      n_fail++;
      $display("FAIL ovr_ack_same: got %h/%b/%0d pulses expected %h/1/1", rx_data, rx_valid, ovr_cnt-o0, e);
    end
    do_ack();
  endtask

  task automatic test_abort();
    logic [15:0] mw, e; int lat; logic bm; int f0;
    exp_rx.push_back(16'h4444);
    spi_frame(16'h4444, 16, -1, 16'h0, 1'b0, mw, lat, bm);
    e = exp_rx.pop_front();
    f0 = ferr_cnt;
    spi_frame(16'hFFFF, 9, -1, 16'h0, 1'b0, mw, lat, bm);
    n_checks++;
    if (ferr_cnt != f0 + 1 || rx_valid !== 1'b1 || rx_data !== e) begin
      n_fail++;
      $display("FAIL abort: got %0d pulses %b/%h expected 1 pulse 1/%h", ferr_cnt-f0, rx_valid, rx_data, e);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
    do_ack();
    exp_tx.push_back(tx_model); exp_rx.push_back(16'hBEEF);
    spi_frame(16'hBEEF, 16, -1, 16'h0, 1'b0, mw, lat, bm);
    e = exp_rx.pop_front(); n_checks++;
    if (rx_data !== e || rx_valid !== 1'b1) begin
      n_fail++; $display("FAIL abort_next_rx: got %h/%b expected %h/1", rx_data, rx_valid, e);
    end
    e = exp_tx.pop_front(); n_checks++;
    if (mw !== e) begin n_fail++; $display("FAIL abort_next_miso: got %h expected %h", mw, e); end
    do_ack();
  endtask

  task automatic test_midload();
    logic [15:0] mw, e; int lat; logic bm;
    do_load(16'hFFFF);
    exp_tx.push_back(tx_model);
    spi_frame(16'hFFFF, 16, 5, 16'h5555, 1'b0, mw, lat, bm);
    e = exp_tx.pop_front(); n_checks++;
    if (mw !== e) begin n_fail++; $display("FAIL midload_cur: got %h expected %h", mw, e); end
    do_ack();
    exp_tx.push_back(tx_model);
    spi_frame(16'h0F0F, 16, -1, 16'h0, 1'b0, mw, lat, bm);
    e = exp_tx.pop_front(); n_checks++;
    if (mw !== e) begin n_fail++; $display("FAIL midload_next: got %h expected %h", mw, e); end
    do_ack();
  endtask

  task automatic test_reset_midframe();
    logic m; logic [15:0] mw, e, w; int lat; logic bm; logic any_miso;
    w = 16'hC3A5; any_miso = 1'b0;
    @(negedge inner_clk); cs = 1'b0;
    repeat (4) @(negedge inner_clk);
    for (int i = 0; i < 7; i++) begin
      sclk_bit(w[i], m);
      repeat (3) @(negedge inner_clk);
    end
    reset = 1'b1; tx_model = '0;
    repeat (2) @(negedge inner_clk);
    n_checks++;
    if ({miso, rx_valid, busy, frame_err, overrun} !== 5'b0 || rx_data !== 16'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got %b/%h expected 00000/0000", {miso, rx_valid, busy, frame_err, overrun}, rx_data);
    end
    reset = 1'b0;
    for (int i = 7; i < 16; i++) begin
      sclk_bit(w[i], m);
      any_miso = any_miso | m;
      repeat (3) @(negedge inner_clk);
    end
    repeat (4) @(negedge inner_clk);
    n_checks++;
    if (rx_valid !== 1'b0 || any_miso !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ignored: rx_valid %b miso_seen %b expected 0 0", rx_valid, any_miso);
    end
    @(negedge inner_clk); cs = 1'b1;
    repeat (6) @(negedge inner_clk);
    exp_tx.push_back(tx_model); exp_rx.push_back(16'h0F0F);
    spi_frame(16'h0F0F, 16, -1, 16'h0, 1'b0, mw, lat, bm);
    e = exp_rx.pop_front(); n_checks++;
    if (rx_data !== e || rx_valid !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_next_rx: got %h/%b expected %h/1", rx_data, rx_valid, e);
    end
    e = exp_tx.pop_front(); n_checks++;
    if (mw !== e) begin n_fail++; $display("FAIL rstmid_next_miso: got %h expected %h", mw, e); end
    do_ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_abort();
    test_midload();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI responder for the 16-bit, LSB-first link driven by the FPGA SPI master, used on the peer board or in loopback benches.
- Oversamples the asynchronous sclk, cs and mosi on the local inner_clk.
- Deserialises each 16-bit frame to a parallel word and shifts out a preloaded 16-bit response on miso in the same frame.

Parameters:
- DATA_WIDTH, 16, frame length in bits; the counter width is derived from it.
- CS_ACTIVE, 1'b0, chip-select active level.
- CPOL, 1'b0, sclk idle level; the sampling edge is the first edge leaving idle inverted (falling edge for CPOL=0).
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (must be 2 or more).

Ports:
- inner_clk  in  1  local oversampling clock; must be at least 8x the sclk frequency.
- reset  in  1  asynchronous, active-high.
- sclk  in  1  SPI clock from the master.
- cs  in  1  chip select from the master.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- tx_data  in  DATA_WIDTH  next response word.
- tx_load  in  1  one-cycle strobe that latches tx_data into the holding register.
- rx_data  out  DATA_WIDTH  last complete received word.
- rx_valid  out  1  high while rx_data is unread.
- rx_ack  in  1  consumer read strobe; clears rx_valid.
- busy  out  1  high while a frame is in progress (cs active).
- frame_err  out  1  one-cycle pulse on an aborted frame.
- overrun  out  1  one-cycle pulse when a frame completes while rx_valid is already high.

Behaviour:
- Reset values (asynchronous, active-high; clock inner_clk): miso=0, rx_data=0, rx_valid=0, busy=0, frame_err=0, overrun=0, tx_hold=0, state=IDLE.
- Synchronisation:
  - sclk, cs and mosi each pass through SYNC_STAGES flip-flops.
  - mosi uses the same depth as sclk so the two stay aligned.
  - Edges are detected on the synchronised sclk: sample edge = falling (CPOL=0), launch edge = rising.
- Protocol:
  - LSB first.
  - mosi is sampled on the sample edge.
  - miso bit 0 is driven within 1 inner_clk of synchronised cs becoming active.
  - Each following bit is launched on the sample edge, after the capture in the same cycle.
  - The master reads miso on the launch edge.
- tx_hold register:
  - tx_load writes tx_hold at any time.
  - On cs activation, tx_hold is copied into tx_shift.
  - A tx_load during a frame does not affect the current frame; it applies to the next one.
  - With no tx_load since the last frame, tx_hold is resent.
- State machine:
  - IDLE: miso=0, busy=0. Synchronised cs active -> load tx_shift, clear bit_cnt, enter SHIFT, busy=1.
  - SHIFT: on each sample edge, rx_shift <= {mosi_s, rx_shift[DATA_WIDTH-1:1]}, tx_shift shifts right, miso <= next bit, bit_cnt++.
    - On the DATA_WIDTH-th sample edge: rx_data <= assembled word (the same cycle), rx_valid=1, enter WAIT_DESEL.
    - cs inactive before DATA_WIDTH edges -> frame_err pulse, discard partial word, enter IDLE.
  - WAIT_DESEL: further sclk edges are ignored and miso=0. cs inactive -> IDLE, busy=0.
- Latency: rx_valid rises SYNC_STAGES+1 inner_clk cycles after the physical last sample edge.
- Handshake:
  - rx_valid stays high until rx_ack.
  - rx_ack in the same cycle as a new completion -> the new word is valid: rx_valid stays 1 and no overrun.
  - Completion while rx_valid=1 without ack -> rx_data is overwritten, overrun pulses, rx_valid stays 1.
- cs inactive and a sample edge in the same cycle: the abort wins and the edge is not counted.
- Reset mid-frame: immediate return to IDLE. The next frame starts only after cs is seen inactive and then active again; WAIT_DESEL is entered if cs is active when reset releases.

Decomposition:
- SPI.vh: frame width define, CS_ACTIVE/CPOL defaults, state encodings (IDLE, SHIFT, WAIT_DESEL), oversampling-ratio comment constant.
- Sub-module spi_sync_edge: an N-stage synchroniser with registered rise/fall pulse outputs, instantiated for sclk and cs. mosi uses the plain synchroniser path only.

Test Plan:
- tx_load with tx_data=16'hA5C3, master sends 16'h1234 at inner_clk/8 -> rx_data=16'h1234, rx_valid=1, master receives 16'hA5C3 LSB first, busy low after cs release.
- Two back-to-back frames 16'h0001 then 16'h8000, rx_ack after each -> both captured, no overrun, second response = same tx_hold.
- Second frame completes without rx_ack -> overrun pulse 1 cycle, rx_data=second word, rx_valid still 1.
- cs deasserted after 9 sclk edges -> frame_err pulse, rx_valid unchanged, next full frame 16'hBEEF received correctly.
- tx_load 16'h5555 mid-frame while sending 16'hFFFF -> current miso stream = 16'hFFFF, next frame = 16'h5555.
- reset asserted at bit 7 with cs held active -> all outputs return to reset values, no rx_valid until cs toggles inactive then active and a full frame completes.
